// File: rtl/flux_frame_scheduler.sv
// rtl/flux_frame_scheduler.sv - frame sequencer for the spectral-flux datapath with beat holdoff and IBI reporting
// Optional SCHED_STATS_EN: builds frames_done_cnt / beats_suppressed_cnt counters (tied to 0 otherwise).
module flux_frame_scheduler #(
    parameter int N              = 8,
    parameter int W              = 16,
    parameter int TIMEOUT        = 64,
    parameter int HOLDOFF_FRAMES = 4,
    parameter int IBI_W          = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 frame_ready,
    output logic                 rd_en,
    output logic [$clog2(N)-1:0] rd_addr,
    input  logic [W-1:0]         rd_data,
    output logic                 mag_valid,
    output logic [W-1:0]         mag_sq,
    input  logic                 sf_frame_done,
    input  logic                 sf_beat_valid,
    output logic                 busy,
    output logic                 beat_pulse,
    output logic [IBI_W-1:0]     ibi_frames,
    output logic                 ibi_valid,
    output logic                 overrun_err,
    output logic                 timeout_err,
    output logic                 align_err,
    output logic [15:0]          frames_done_cnt,
    output logic [15:0]          beats_suppressed_cnt
);
    localparam int AW = $clog2(N);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    typedef enum logic [1:0] {IDLE, READ, WAIT_DONE} state_t;

    state_t           state;
    logic             pending;
    logic             first_beat;
    logic [TW-1:0]    wait_cnt;
    logic [HW-1:0]    holdoff_cnt;
    logic [IBI_W-1:0] since_beat;

    assign mag_sq = rd_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            mag_valid   <= 1'b0;
            pending     <= 1'b0;
            wait_cnt    <= '0;
            holdoff_cnt <= '0;
            since_beat  <= '0;
            first_beat  <= 1'b1;
            beat_pulse  <= 1'b0;
            ibi_frames  <= '0;
            ibi_valid   <= 1'b0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            mag_valid  <= rd_en;
            beat_pulse <= 1'b0;
            ibi_valid  <= 1'b0;

            // Any request that cannot start right now lands in the one-deep pending slot.
            if (frame_ready && !(state == IDLE && enable)) begin
                if (pending)
                    overrun_err <= 1'b1;
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if ((frame_ready || pending) && enable) begin
                        state   <= READ;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                        pending <= pending & frame_ready;
                    end
                end
                READ: begin
                    if (rd_addr == AW'(N - 1)) begin
                        state    <= WAIT_DONE;
                        rd_en    <= 1'b0;
                        rd_addr  <= '0;
                        wait_cnt <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (sf_frame_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rd_en <= 1'b0;
                end
            endcase

            // Beat post-processing runs on every frame completion regardless of state.
            if (sf_frame_done) begin
                if (state != WAIT_DONE)
                    align_err <= 1'b1;
                if (since_beat != '1)
                    since_beat <= since_beat + 1'b1;
                if (holdoff_cnt != '0) begin
                    holdoff_cnt <= holdoff_cnt - 1'b1;
                end else if (sf_beat_valid) begin
                    beat_pulse  <= 1'b1;
                    holdoff_cnt <= HW'(HOLDOFF_FRAMES);
                    if (!first_beat) begin
                        ibi_frames <= (since_beat == '1) ? since_beat : since_beat + 1'b1;
                        ibi_valid  <= 1'b1;
                    end
                    first_beat <= 1'b0;
                    since_beat <= '0;
                end
            end
        end
    end

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frames_done_cnt      <= '0;
            beats_suppressed_cnt <= '0;
        end else if (sf_frame_done) begin
            frames_done_cnt <= frames_done_cnt + 1'b1;
            if (sf_beat_valid && holdoff_cnt != '0)
                beats_suppressed_cnt <= beats_suppressed_cnt + 1'b1;
        end
    end
`else
    assign frames_done_cnt      = '0;
    assign beats_suppressed_cnt = '0;
`endif

endmodule
